transaccion_word_counter: RTL and testbench

//  Responder end of the req/idx counter-query interface of the transaction layer.

---
 rtl/transaccion_word_counter.sv | 95 +++++++++
 tb/tb_transaccion_word_counter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/transaccion_word_counter.sv
// Per-lane popped-word counters for the transaction layer output FIFOs.
// When the layer FSM is idle, a level-sensitive req/idx query is answered one
// cycle later with the count of the selected lane on o_data/o_valid.
module transaccion_word_counter #(
   parameter  int unsigned NUM_LANES = 4,
   parameter  int unsigned CNT_WIDTH = 5,
   localparam int unsigned IDX_WIDTH = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_init,
   input  logic                 i_idle,
   input  logic [NUM_LANES-1:0] i_pop_fifo_out,
   input  logic [NUM_LANES-1:0] i_fifo_out_empty,
   input  logic                 i_req,
   input  logic [IDX_WIDTH-1:0] i_idx,
   output logic [CNT_WIDTH-1:0] o_data,
   output logic                 o_valid
);

   localparam logic [CNT_WIDTH-1:0] CntMax = '1;
   localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      StCount = 1'b0,
      StReady = 1'b1
   } state_e;

   state_e               r_state;
   state_e               w_state_next;
   logic [CNT_WIDTH-1:0] r_cnt [NUM_LANES];
   logic [NUM_LANES-1:0] w_pop_eff;
   logic                 w_ans_valid;
   logic [CNT_WIDTH-1:0] w_ans_data;

   // A pop only moves a word when the FIFO actually holds one.
   always_comb begin
      w_pop_eff = i_pop_fifo_out & ~i_fifo_out_empty;
   end

   // Saturating per-lane counters; init clears and swallows same-cycle pops.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_init) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (w_pop_eff[i] && (r_cnt[i] != CntMax)) begin
               r_cnt[i] <= r_cnt[i] + CntOne;
            end
         end
      end
   end

   // State register: COUNT while the layer is busy, READY while it is idle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StCount;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic follows the idle flag.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StCount: if (i_idle)  w_state_next = StReady;
         StReady: if (!i_idle) w_state_next = StCount;
         default: w_state_next = StCount;
      endcase
   end

   // Answer is the pre-increment count of the selected lane; zero when not answering.
   always_comb begin
      w_ans_valid = (r_state == StReady) && i_req && !i_init;
      w_ans_data  = '0;
      if (w_ans_valid) begin
         w_ans_data = r_cnt[i_idx];
      end
   end

   // Registered outputs so data/valid never depend combinationally on inputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_data  <= '0;
         o_valid <= 1'b0;
      end else begin
         o_data  <= w_ans_data;
         o_valid <= w_ans_valid;
      end
   end

endmodule

// File: tb/tb_transaccion_word_counter.sv
// Scoreboard bench for transaccion_word_counter: the stimulus task pushes the
// expected next-cycle output from a counting model; a monitor pops and compares.
module tb_transaccion_word_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       init = 1'b0;
   logic       idle = 1'b0;
   logic [3:0] pop = 4'h0;
   logic [3:0] empty = 4'h0;
   logic       req = 1'b0;
   logic [1:0] idx = 2'd0;
   logic [4:0] data;
   logic       valid;

   always #5 clk = ~clk;

   transaccion_word_counter #(
      .NUM_LANES (4),
      .CNT_WIDTH (5)
   ) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_init           (init),
      .i_idle           (idle),
      .i_pop_fifo_out   (pop),
      .i_fifo_out_empty (empty),
      .i_req            (req),
      .i_idx            (idx),
      .o_data           (data),
      .o_valid          (valid)
   );

   typedef struct packed {
      logic       v;
      logic [4:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: plain integer counts and an "answering" flag.
   int   cnt_m[4] = '{0, 0, 0, 0};
   bit   ready_m = 1'b0;

   // One clock of stimulus; the model predicts what the DUT shows after the next edge.
   task automatic drive(input logic rst, input logic ini, input logic idl,
                        input logic [3:0] pp, input logic [3:0] emp,
                        input logic rq, input logic [1:0] ix);
      exp_t e;
      @(negedge clk);
      reset = rst;
      init  = ini;
      idle  = idl;
      pop   = pp;
      empty = emp;
      req   = rq;
      idx   = ix;
      e.v = 1'b0;
      e.d = 5'd0;
      if (!rst && ready_m && rq && !ini) begin
         e.v = 1'b1;
         e.d = 5'(cnt_m[ix]);
      end
      exp_q.push_back(e);
      for (int i = 0; i < 4; i++) begin
         if (rst || ini) cnt_m[i] = 0;
         else if (pp[i] && !emp[i] && cnt_m[i] < 31) cnt_m[i] = cnt_m[i] + 1;
      end
      ready_m = rst ? 1'b0 : idl;
   endtask

   // Monitor: every cycle the DUT presents an output, compare it with the oldest prediction.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (valid !== e.v || data !== e.d) begin
               failures++;
               $display("FAIL output t=%0t: got valid=%0b data=%0d, expected valid=%0b data=%0d",
                        $time, valid, data, e.v, e.d);
            end
         end
      end
   end

   initial begin : stimulus
      // Reset held with pops and req active.
      repeat (2) drive(1, 0, 1, 4'hF, 4'h0, 1, 2'd1);
      // Query straight after reset: all lanes must read zero.
      drive(0, 0, 1, 4'h0, 4'h0, 0, 2'd0);
      for (int l = 0; l < 4; l++) drive(0, 0, 1, 4'h0, 4'h0, 1, 2'(l));
      // Basic count: five effective pops per lane while busy.
      repeat (5) drive(0, 0, 0, 4'hF, 4'h0, 0, 2'd0);
      // Gating: pops on empty FIFOs, and req while busy.
      repeat (3) drive(0, 0, 0, 4'hF, 4'hF, 1, 2'd2);
      drive(0, 0, 1, 4'h0, 4'h0, 0, 2'd0);
      for (int l = 0; l < 4; l++) repeat (3) drive(0, 0, 1, 4'h0, 4'h0, 1, 2'(l));
      // Accumulate: four more pops, no clear on read.
      repeat (4) drive(0, 0, 0, 4'hF, 4'h0, 0, 2'd0);
      drive(0, 0, 1, 4'h0, 4'h0, 0, 2'd0);
      for (int l = 0; l < 4; l++) repeat (2) drive(0, 0, 1, 4'h0, 4'h0, 1, 2'(l));
      // Saturation on lane 2, then init clears it (same-cycle pop dropped).
      repeat (40) drive(0, 0, 0, 4'b0100, 4'h0, 0, 2'd0);
      drive(0, 0, 1, 4'h0, 4'h0, 0, 2'd0);
      repeat (2) drive(0, 0, 1, 4'h0, 4'h0, 1, 2'd2);
      drive(0, 1, 1, 4'b0100, 4'h0, 1, 2'd2);
      repeat (2) drive(0, 0, 1, 4'h0, 4'h0, 1, 2'd2);
      // Collision: query lane 1 while it pops.
      repeat (3) drive(0, 0, 0, 4'b0010, 4'h0, 0, 2'd0);
      drive(0, 0, 1, 4'h0, 4'h0, 0, 2'd0);
      drive(0, 0, 1, 4'b0010, 4'h0, 1, 2'd1);
      repeat (2) drive(0, 0, 1, 4'h0, 4'h0, 1, 2'd1);
      // idle falls while req is held, then reset mid-query.
      repeat (3) drive(0, 0, 0, 4'h0, 4'h0, 1, 2'd1);
      repeat (2) drive(0, 0, 1, 4'h0, 4'h0, 1, 2'd0);
      drive(1, 0, 1, 4'hF, 4'h0, 1, 2'd0);
      repeat (2) drive(0, 0, 1, 4'h0, 4'h0, 1, 2'd3);
      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         drive(($urandom % 80) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
               4'($urandom), 4'($urandom & $urandom), ($urandom % 4) != 0, 2'($urandom));
      end
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
